// File: rtl/aes_kb_search.sv
// Sequences one aes_kb key-check unit across a candidate range; stops on match, exhaustion, abort or watchdog.
// Latency: first kb_start one cycle after cmd_start; a terminating kb_done yields search_done one cycle later.
// Backpressure: stall freezes all state and suppresses kb_start; aes_kb is stalled alongside via kb_stall.
module aes_kb_search #(
    parameter int TIMEOUT = 256,
    parameter int IDX_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    input  logic [447:0]       seed,
    input  logic [127:0]       enc_hash,
    input  logic [IDX_W-1:0]   count,
    output logic               kb_start,
    output logic               kb_stall,
    output logic [447:0]       kb,
    output logic [127:0]       in_buf,
    input  logic               kb_done,
    input  logic               kb_valid,
    output logic               busy,
    output logic               search_done,
    output logic               found,
    output logic               exhausted,
    output logic               aborted,
    output logic               timeout_err,
    output logic [IDX_W-1:0]   found_idx,
    output logic [IDX_W-1:0]   tried
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]       state;
    logic [31:0]      seed_lo_q;
    logic [IDX_W-1:0] count_q;
    logic [IDX_W-1:0] idx;
    logic [WD_W-1:0]  wd;
    logic             zero_q;

    // An aborted ISSUE never starts a job, so no orphan kb_done can leak into the next search.
    assign kb_start    = (state == S_ISSUE) && !stall && !cmd_abort;
    assign kb_stall    = stall;
    assign busy        = (state != S_IDLE);
    assign search_done = (state == S_FINISH) && !zero_q && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            seed_lo_q   <= '0;
            count_q     <= '0;
            idx         <= '0;
            wd          <= '0;
            zero_q      <= 1'b0;
            kb          <= '0;
            in_buf      <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
            found_idx   <= '0;
            tried       <= '0;
        end else if (!stall) begin
            case (state)
                S_IDLE: begin
                    if (cmd_start) begin
                        seed_lo_q   <= seed[31:0];
                        kb          <= seed;
                        in_buf      <= enc_hash;
                        count_q     <= count;
                        idx         <= '0;
                        tried       <= '0;
                        found       <= 1'b0;
                        aborted     <= 1'b0;
                        timeout_err <= 1'b0;
                        found_idx   <= '0;
                        if (count == '0) begin
                            exhausted <= 1'b1;
                            zero_q    <= 1'b1;
                            state     <= S_FINISH;
                        end else begin
                            exhausted <= 1'b0;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wd <= '0;
                    if (cmd_abort) begin
                        aborted <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (kb_done) begin
                        tried <= tried + IDX_W'(1);
                        if (kb_valid) begin
                            found     <= 1'b1;
                            found_idx <= idx;
                            state     <= S_FINISH;
                        end else if (idx == count_q - IDX_W'(1)) begin
                            exhausted <= 1'b1;
                            state     <= S_FINISH;
                        end else begin
                            idx       <= idx + IDX_W'(1);
                            kb[31:0]  <= seed_lo_q + 32'(idx + IDX_W'(1));
                            state     <= S_GAP;
                        end
                    end else if (cmd_abort) begin
                        wd    <= wd + WD_W'(1);
                        state <= S_DRAIN;
                    end else if (wd == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_GAP: begin
                    if (cmd_abort) begin
                        aborted <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    // The in-flight job's result is discarded; only its completion is awaited.
                    if (kb_done || wd >= WD_LAST) begin
                        aborted <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_FINISH: begin
                    // A zero-count search holds FINISH one extra cycle so search_done lands two cycles after the start.
                    if (zero_q) begin
                        zero_q <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_kb_search.sv
// Directed bench for aes_kb_search with a behavioural aes_kb model (fixed latency, selectable matching job).
module tb_aes_kb_search;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic         cmd_start;
    logic         cmd_abort;
    logic [447:0] seed;
    logic [127:0] enc_hash;
    logic [31:0]  count;
    logic         kb_start;
    logic         kb_stall;
    logic [447:0] kb;
    logic [127:0] in_buf;
    logic         kb_done;
    logic         kb_valid;
    logic         busy;
    logic         search_done;
    logic         found;
    logic         exhausted;
    logic         aborted;
    logic         timeout_err;
    logic [31:0]  found_idx;
    logic [31:0]  tried;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int lat;
    int valid_job;
    bit nodone;
    int timer;
    int job_num;
    int ndone;
    int sd_count;
    int sd_cycle;
    int upper_bad;
    int c0;
    int start_log [16];
    int done_log  [16];
    logic [31:0]  kb_lo_log [16];
    logic [415:0] exp_upper;

    aes_kb_search #(.TIMEOUT(256), .IDX_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .seed(seed), .enc_hash(enc_hash), .count(count), .kb_start(kb_start), .kb_stall(kb_stall),
        .kb(kb), .in_buf(in_buf), .kb_done(kb_done), .kb_valid(kb_valid), .busy(busy),
        .search_done(search_done), .found(found), .exhausted(exhausted), .aborted(aborted),
        .timeout_err(timeout_err), .found_idx(found_idx), .tried(tried)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // aes_kb model and event recorder, evaluated mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            timer    = 0;
            kb_done  = 1'b0;
            kb_valid = 1'b0;
        end else begin
            kb_done  = 1'b0;
            kb_valid = 1'b0;
            if (!stall && timer > 0) begin
                timer--;
                if (timer == 0) begin
                    kb_done  = 1'b1;
                    kb_valid = (valid_job != 0) && (job_num == valid_job);
                    if (ndone < 16) done_log[ndone] = cyc;
                    ndone++;
                end
            end
            if (kb_start) begin
                if (job_num < 16) begin
                    start_log[job_num] = cyc;
                    kb_lo_log[job_num] = kb[31:0];
                end
                job_num++;
                timer = nodone ? 0 : lat;
                if (kb[447:32] !== exp_upper) upper_bad++;
            end
            if (search_done) begin
                sd_count++;
                sd_cycle = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [447:0] s, input logic [31:0] n, input int l,
                            input int vj, input bit nd);
        seed      = s;
        count     = n;
        enc_hash  = {s[63:0], ~s[63:0]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        exp_upper = s[447:32];
        lat       = l;
        valid_job = vj;
        nodone    = nd;
        job_num   = 0;
        ndone     = 0;
        sd_count  = 0;
        upper_bad = 0;
        c0        = cyc;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sd_count == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sd_count == 0) begin
            failures++;
            $display("FAIL search_done_timeout got=none exp=pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (kb_start !== 1'b0) begin failures++; $display("FAIL rst_kb_start got=%b exp=0", kb_start); end
        checks++; if (kb !== 448'd0) begin failures++; $display("FAIL rst_kb got=%h exp=0", kb[31:0]); end
        checks++; if (in_buf !== 128'd0) begin failures++; $display("FAIL rst_in_buf got=%h exp=0", in_buf); end
        checks++; if ({search_done, found, exhausted, aborted, timeout_err} !== 5'b0) begin
            failures++; $display("FAIL rst_status got=%b exp=00000", {search_done, found, exhausted, aborted, timeout_err});
        end
        checks++; if (tried !== 32'd0 || found_idx !== 32'd0) begin
            failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", tried, found_idx);
        end
    endtask

    task automatic test_found;
        do_start(448'd0, 32'd5, 4, 3, 1'b0);
        checks++; if (busy !== 1'b1 || kb_start !== 1'b1) begin
            failures++; $display("FAIL found_issue_cycle got=busy%b/start%b exp=1/1", busy, kb_start);
        end
        wait_done(200);
        checks++; if (job_num != 3) begin failures++; $display("FAIL found_jobs got=%0d exp=3", job_num); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (kb_lo_log[i] !== 32'(i)) begin
                failures++; $display("FAIL found_kb_lo[%0d] got=%h exp=%h", i, kb_lo_log[i], i);
            end
        end
        checks++; if (found !== 1'b1 || exhausted !== 1'b0) begin
            failures++; $display("FAIL found_flag got=%b/%b exp=1/0", found, exhausted);
        end
        checks++; if (found_idx !== 32'd2) begin failures++; $display("FAIL found_idx got=%0d exp=2", found_idx); end
        checks++; if (tried !== 32'd3) begin failures++; $display("FAIL found_tried got=%0d exp=3", tried); end
        checks++; if (in_buf !== enc_hash) begin failures++; $display("FAIL found_in_buf got=%h exp=%h", in_buf, enc_hash); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL found_busy_fall got=%b exp=0", busy); end
        tick();
        checks++; if (sd_count != 1) begin failures++; $display("FAIL found_sd_pulses got=%0d exp=1", sd_count); end
    endtask

    task automatic test_exhaust;
        do_start({416'h1234, 32'd100}, 32'd4, 3, 0, 1'b0);
        wait_done(200);
        checks++; if (job_num != 4) begin failures++; $display("FAIL exh_jobs got=%0d exp=4", job_num); end
        checks++; if (exhausted !== 1'b1 || found !== 1'b0) begin
            failures++; $display("FAIL exh_flag got=%b/%b exp=1/0", exhausted, found);
        end
        checks++; if (tried !== 32'd4) begin failures++; $display("FAIL exh_tried got=%0d exp=4", tried); end
        checks++; if (start_log[0] != c0 + 1) begin
            failures++; $display("FAIL exh_first_start got=%0d exp=%0d", start_log[0], c0 + 1);
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if (start_log[i] != done_log[i-1] + 2) begin
                failures++; $display("FAIL exh_gap[%0d] got=%0d exp=%0d", i, start_log[i], done_log[i-1] + 2);
            end
        end
        checks++; if (sd_cycle != done_log[3] + 1) begin
            failures++; $display("FAIL exh_sd_cycle got=%0d exp=%0d", sd_cycle, done_log[3] + 1);
        end
        checks++; if (kb_lo_log[3] !== 32'd103) begin failures++; $display("FAIL exh_kb_lo3 got=%0d exp=103", kb_lo_log[3]); end
    endtask

    task automatic test_zero_count;
        do_start({416'h55, 32'd7}, 32'd0, 3, 0, 1'b0);
        wait_done(20);
        repeat (3) tick();
        checks++; if (job_num != 0) begin failures++; $display("FAIL zero_jobs got=%0d exp=0", job_num); end
        checks++; if (sd_cycle != c0 + 2) begin failures++; $display("FAIL zero_sd_cycle got=%0d exp=%0d", sd_cycle, c0 + 2); end
        checks++; if (exhausted !== 1'b1 || tried !== 32'd0) begin
            failures++; $display("FAIL zero_status got=%b/%0d exp=1/0", exhausted, tried);
        end
        checks++; if (sd_count != 1) begin failures++; $display("FAIL zero_sd_pulses got=%0d exp=1", sd_count); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_lo [3];
        exp_lo[0] = 32'hFFFF_FFFE;
        exp_lo[1] = 32'hFFFF_FFFF;
        exp_lo[2] = 32'h0000_0000;
        do_start({{13{32'hA5C3_0F1E}}, 32'hFFFF_FFFE}, 32'd3, 2, 0, 1'b0);
        wait_done(200);
        checks++; if (job_num != 3) begin failures++; $display("FAIL wrap_jobs got=%0d exp=3", job_num); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (kb_lo_log[i] !== exp_lo[i]) begin
                failures++; $display("FAIL wrap_kb_lo[%0d] got=%h exp=%h", i, kb_lo_log[i], exp_lo[i]);
            end
        end
        checks++; if (upper_bad != 0) begin failures++; $display("FAIL wrap_upper got=%0d bad exp=0", upper_bad); end
    endtask

    task automatic test_abort;
        do_start({416'h9, 32'd0}, 32'd5, 25, 0, 1'b0);
        while (cyc < c0 + 6) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done(100);
        repeat (4) tick();
        checks++; if (job_num != 1) begin failures++; $display("FAIL abort_jobs got=%0d exp=1", job_num); end
        checks++; if (aborted !== 1'b1 || exhausted !== 1'b0 || found !== 1'b0) begin
            failures++; $display("FAIL abort_flags got=%b%b%b exp=100", aborted, exhausted, found);
        end
        checks++; if (done_log[0] != c0 + 26) begin failures++; $display("FAIL abort_done_cycle got=%0d exp=%0d", done_log[0], c0 + 26); end
        checks++; if (sd_cycle != done_log[0] + 1) begin
            failures++; $display("FAIL abort_sd_cycle got=%0d exp=%0d", sd_cycle, done_log[0] + 1);
        end
        checks++; if (tried !== 32'd0) begin failures++; $display("FAIL abort_tried got=%0d exp=0", tried); end
    endtask

    task automatic test_abort_with_done;
        do_start({416'h3, 32'd40}, 32'd5, 4, 1, 1'b0);
        while (cyc < c0 + 5) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done(100);
        checks++; if (found !== 1'b1 || aborted !== 1'b0) begin
            failures++; $display("FAIL abort_race_flags got=found%b/aborted%b exp=1/0", found, aborted);
        end
        checks++; if (found_idx !== 32'd0 || tried !== 32'd1) begin
            failures++; $display("FAIL abort_race_result got=%0d/%0d exp=0/1", found_idx, tried);
        end
    endtask

    task automatic test_reset_mid;
        do_start({416'h7, 32'd1}, 32'd8, 30, 0, 1'b0);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || kb_start !== 1'b0 || kb !== 448'd0 || tried !== 32'd0) begin
            failures++; $display("FAIL reset_mid got=busy%b start%b kb_lo%h exp=0/0/0", busy, kb_start, kb[31:0]);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_timeout;
        do_start({416'h11, 32'd0}, 32'd4, 0, 0, 1'b1);
        while (cyc < c0 + 257) tick();
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL timeout_early got=%b/%b exp=0/1", timeout_err, busy);
        end
        tick();
        checks++; if (timeout_err !== 1'b1 || search_done !== 1'b1) begin
            failures++; $display("FAIL timeout_edge got=err%b/sd%b exp=1/1", timeout_err, search_done);
        end
        tick();
        checks++; if (busy !== 1'b0 || tried !== 32'd0 || aborted !== 1'b0) begin
            failures++; $display("FAIL timeout_after got=busy%b tried%0d aborted%b exp=0/0/0", busy, tried, aborted);
        end
    endtask

    task automatic test_stall;
        do_start({416'h22, 32'd0}, 32'd4, 0, 0, 1'b1);
        while (cyc < c0 + 52) tick();
        stall = 1'b1;
        tick();
        checks++; if (kb_stall !== 1'b1) begin failures++; $display("FAIL stall_pass got=%b exp=1", kb_stall); end
        while (cyc < c0 + 102) tick();
        stall = 1'b0;
        while (cyc < c0 + 258) tick();
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL stall_frozen got=err%b busy%b exp=0/1", timeout_err, busy);
        end
        while (cyc < c0 + 307) tick();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL stall_early got=%b exp=0", timeout_err); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL stall_timeout got=%b exp=1", timeout_err); end
        repeat (2) tick();
    endtask

    initial begin
        rst       = 1'b0;
        stall     = 1'b0;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        seed      = '0;
        enc_hash  = '0;
        count     = '0;
        lat       = 4;
        valid_job = 0;
        nodone    = 1'b0;
        job_num   = 0;
        ndone     = 0;
        sd_count  = 0;
        sd_cycle  = 0;
        upper_bad = 0;
        timer     = 0;
        exp_upper = '0;
        repeat (3) tick();
        test_reset();
        rst = 1'b1;
        repeat (2) tick();
        test_found();
        test_exhaust();
        test_zero_count();
        test_wrap();
        test_abort();
        test_abort_with_done();
        test_reset_mid();
        test_timeout();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
